enc_8x3_seq: RTL and testbench
==============================

ENC_8X3_SEQ -- requirements
Module: enc_8x3_seq

Interface
REQ-001 SHALL have parameter PRIO_MSB, default 0; 0 = lowest set index emitted first, 1 = highest set index emitted first.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port d  input  8  request word; bit i set = index i pending.
REQ-005 SHALL have port d_valid  input  1  d holds a word to be accepted.
REQ-006 SHALL have port d_ready  output  1  block can accept d this cycle.
REQ-007 SHALL have port y  output  3  encoded index of current pending bit.
REQ-008 SHALL have port y_valid  output  1  y is valid.
REQ-009 SHALL have port y_ready  input  1  downstream consumes y this cycle.
REQ-010 SHALL have port y_last  output  1  current y is the final index of its word.
REQ-011 SHALL have port zero  output  1  one-cycle pulse: an all-zero word was accepted.

Function
REQ-012 SHALL hold an 8-bit pending register and a two-state FSM: IDLE, EMIT.
REQ-013 SHALL accept a word only on a rising edge with d_valid=1 and d_ready=1 (handshake).
REQ-014 SHALL drive d_ready=1 in IDLE, and in EMIT only when y_valid=1, y_ready=1 and y_last=1 (back-to-back word acceptance; combinational y_ready->d_ready path is permitted).
REQ-015 IDLE, accept, d!=0: SHALL load pending=d and enter EMIT; first y_valid in the next cycle (latency 1).
REQ-016 IDLE, accept, d=0: SHALL stay IDLE, leave pending=0, assert zero for exactly the next cycle, emit nothing.
REQ-017 EMIT: SHALL drive y_valid=1, y = priority index of pending per PRIO_MSB, y_last=1 iff exactly one pending bit set.
REQ-018 In IDLE SHALL drive y_valid=0, y_last=0, y=0.
REQ-019 EMIT with y_ready=0: SHALL hold y, y_valid, y_last, pending unchanged (no drop, no skip).
REQ-020 EMIT, y handshake, y_last=0: SHALL clear only the emitted bit in pending, stay EMIT.
REQ-021 EMIT, y handshake, y_last=1, no new accept: SHALL clear pending, go IDLE.
REQ-022 EMIT, y handshake, y_last=1, simultaneous accept: nonzero d SHALL load pending=d, stay EMIT with no idle bubble; zero d SHALL go IDLE and pulse zero.
REQ-023 Each set bit of an accepted word SHALL be emitted exactly once, in strict priority order; a word with k set bits SHALL yield exactly k handshakes.
REQ-024 Input d SHALL be ignored whenever no accept handshake occurs.

Reset
REQ-025 rst=1 SHALL immediately (no clock) force state=IDLE, pending=0, y=0, y_valid=0, y_last=0, zero=0, d_ready=1.
REQ-026 rst asserted mid-EMIT SHALL discard the in-progress word; no further indices of it emitted after release.
REQ-027 First accept after rst deasserts SHALL be possible on the first rising edge.

Structure
REQ-028 Shared package enc_pkg SHALL hold: state typedef (IDLE, EMIT), constants IN_W=8, OUT_W=3.
REQ-029 Priority logic SHALL be one combinational sub-module pri_enc_8x3 (inputs: 8-bit word, direction; outputs: 3-bit index, any-set, exactly-one-set), instantiated once on pending.
REQ-030 Target size 120-400 lines RTL total.

Verification
REQ-031 rst pulse, then d=8'b1010_0100, d_valid 1 cycle, y_ready=1, PRIO_MSB=0 -> y=2,5,7 on consecutive cycles, y_last only with 7, then IDLE, d_ready=1.
REQ-032 Same word, PRIO_MSB=1 -> y=7,5,2; y_last with 2.
REQ-033 d=8'h00 accepted -> zero high exactly one cycle, y_valid never asserted, d_ready stays 1.
REQ-034 d=8'hFF, y_ready toggling 1/0 each cycle -> y=0..7 each held while y_ready=0, 8 handshakes total, none repeated.
REQ-035 d=8'h81 then d=8'h10 held valid, y_ready=1 -> y=0,7,4 on three consecutive cycles, second word accepted on y=7 cycle.
REQ-036 d=8'h0F, rst asserted asynchronously after y=1 handshake -> y_valid drops at once; after release, indices 2,3 never appear, d_ready=1.

Source files
------------

// File: rtl/enc_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
// Shared types and widths for the sequential 8-to-3 encoder.
//   state_t : controller state (IDLE = waiting for a word, EMIT = streaming
//             indices of the pending word)
//   IN_W    : request word width
//   OUT_W   : encoded index width
// -----------------------------------------------------------------------------
package enc_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage : enc_pkg

// File: rtl/pri_enc_8x3.sv
// -----------------------------------------------------------------------------
// pri_enc_8x3
// Combinational priority encoder with selectable direction.
//   word      in  [IN_W-1:0]  bits to encode
//   msb_first in  1           1 = highest set bit wins, 0 = lowest set bit wins
//   idx       out [OUT_W-1:0] index of the winning bit (0 when word is zero)
//   any       out 1           at least one bit of word is set
//   one       out 1           exactly one bit of word is set
// -----------------------------------------------------------------------------
module pri_enc_8x3
  import enc_pkg::*;
(
  input  logic [IN_W-1:0]  word,
  input  logic             msb_first,
  output logic [OUT_W-1:0] idx,
  output logic             any,
  output logic             one
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    idx = '0;
    // Scan towards the winning end; the last set bit seen overwrites earlier
    // ones, so the scan order alone decides the priority direction.
    if (msb_first) begin
      for (int i = 0; i < IN_W; i++) begin
        if (word[i]) idx = OUT_W'(i);
      end
    end else begin
      for (int i = IN_W - 1; i >= 0; i--) begin
        if (word[i]) idx = OUT_W'(i);
      end
    end
    any = |word;
    // Clearing the lowest set bit leaves zero only for a one-hot word.
    one = any && ((word & (word - IN_W'(1))) == '0);
  end

endmodule : pri_enc_8x3

// File: rtl/enc_8x3_seq.sv
// -----------------------------------------------------------------------------
// enc_8x3_seq
// Sequential 8-to-3 encoder. Accepts an 8-bit request word and emits the index
// of every set bit, one per output handshake, in priority order.
//   PRIO_MSB      0 = lowest set index first, 1 = highest set index first
//   clk     in  1  clock, rising edge
//   rst     in  1  asynchronous active-high reset
//   d       in  8  request word
//   d_valid in  1  d holds a word to be accepted
//   d_ready out 1  a word can be accepted this cycle
//   y       out 3  index of the current pending bit
//   y_valid out 1  y is valid
//   y_ready in  1  downstream consumes y this cycle
//   y_last  out 1  y is the final index of its word
//   zero    out 1  one-cycle pulse after an all-zero word is accepted
// -----------------------------------------------------------------------------
module enc_8x3_seq
  import enc_pkg::*;
#(
  parameter bit PRIO_MSB = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  d,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [OUT_W-1:0] y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             y_last,
  output logic             zero
);

  state_t            state_q, state_d;
  logic [IN_W-1:0]   pending_q, pending_d;
  logic              zero_q, zero_d;

  logic [OUT_W-1:0]  pri_idx;
  logic              pri_any;
  logic              pri_one;
  logic              accept;
  logic              y_hs;
  logic              word_zero;

  pri_enc_8x3 u_pri_enc (
    .word      (pending_q),
    .msb_first (PRIO_MSB),
    .idx       (pri_idx),
    .any       (pri_any),
    .one       (pri_one)
  );

  // State register. Outputs decode from these flops combinationally, so an
  // asserted rst forces them to their idle values without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

  // Output decode. d_ready depends combinationally on y_ready so the next word
  // can be taken on the same edge that retires the last index (no bubble).
  always_comb begin
    y_valid   = (state_q == EMIT) && pri_any;
    y         = y_valid ? pri_idx : '0;
    y_last    = y_valid && pri_one;
    d_ready   = (state_q == IDLE) || (y_valid && y_ready && y_last);
    zero      = zero_q;
    accept    = d_valid && d_ready;
    y_hs      = y_valid && y_ready;
    word_zero = (d == '0);
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (word_zero) begin
            zero_d = 1'b1;
          end else begin
            pending_d = d;
            state_d   = EMIT;
          end
        end
      end
      EMIT: begin
        if (y_hs) begin
          if (!y_last) begin
            // Retire only the bit just emitted; the encoder then picks the next.
            pending_d = pending_q & ~(IN_W'(1) << pri_idx);
          end else if (accept && !word_zero) begin
            pending_d = d;
          end else begin
            pending_d = '0;
            state_d   = IDLE;
            zero_d    = accept;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

endmodule : enc_8x3_seq

// File: tb/tb_enc_8x3_seq.sv
// -----------------------------------------------------------------------------
// tb_enc_8x3_seq
// Drives one LSB-first and one MSB-first instance with identical stimulus.
// Both accept words at the same moments (a word with k bits takes k
// handshakes in either direction), so one input stream serves both. Expected
// values come from a hand-written vector table and from a queue model that
// lists each accepted word's set-bit indices in priority order.
// -----------------------------------------------------------------------------
module tb_enc_8x3_seq;
  import enc_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  d;
  logic             d_valid;
  logic             y_ready;

  logic             d_ready_l, y_valid_l, y_last_l, zero_l;
  logic [OUT_W-1:0] y_l;
  logic             d_ready_m, y_valid_m, y_last_m, zero_m;
  logic [OUT_W-1:0] y_m;

  int errors = 0;
  int checks = 0;

  // Reference model: remaining indices of the current word, front = next out.
  int q_lsb[$];
  int q_msb[$];
  bit zero_exp;

  always #5 clk = ~clk;

  enc_8x3_seq #(.PRIO_MSB(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(d_ready_l),
    .y(y_l), .y_valid(y_valid_l), .y_ready(y_ready), .y_last(y_last_l),
    .zero(zero_l)
  );

  enc_8x3_seq #(.PRIO_MSB(1'b1)) u_msb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(d_ready_m),
    .y(y_m), .y_valid(y_valid_m), .y_ready(y_ready), .y_last(y_last_m),
    .zero(zero_m)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    q_lsb.delete();
    q_msb.delete();
    zero_exp = 1'b0;
  endfunction

  function automatic void model_load(input logic [7:0] w);
    for (int i = 0; i < 8; i++) if (w[i]) q_lsb.push_back(i);
    for (int i = 7; i >= 0; i--) if (w[i]) q_msb.push_back(i);
  endfunction

  task automatic check_model();
    int n;
    n = q_lsb.size();
    check("lsb y_valid", y_valid_l, n > 0);
    check("lsb y", y_l, (n > 0) ? q_lsb[0] : 0);
    check("lsb y_last", y_last_l, n == 1);
    check("lsb d_ready", d_ready_l, (n == 0) || (y_ready && n == 1));
    check("lsb zero", zero_l, zero_exp);
    n = q_msb.size();
    check("msb y_valid", y_valid_m, n > 0);
    check("msb y", y_m, (n > 0) ? q_msb[0] : 0);
    check("msb y_last", y_last_m, n == 1);
    check("msb d_ready", d_ready_m, (n == 0) || (y_ready && n == 1));
    check("msb zero", zero_m, zero_exp);
  endtask

  // Called just after a rising edge, while the inputs of that edge still hold.
  function automatic void model_step();
    bit acc;
    acc = d_valid && (q_lsb.size() == 0 || (y_ready && q_lsb.size() == 1));
    if (q_lsb.size() > 0 && y_ready) begin
      void'(q_lsb.pop_front());
      void'(q_msb.pop_front());
    end
    zero_exp = acc && (d == 8'h00);
    if (acc && d != 8'h00) model_load(d);
  endfunction

  task automatic apply(input logic [7:0] dd, input logic dv, input logic yr);
    d       = dd;
    d_valid = dv;
    y_ready = yr;
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle(input logic [7:0] dd, input logic dv, input logic yr);
    apply(dd, dv, yr);
    advance();
  endtask

  // Asynchronous reset: asserted between edges, outputs checked before any
  // clock, released just after an edge so the next edge can accept.
  task automatic do_reset();
    d_valid = 1'b0;
    rst     = 1'b1;
    #1;
    model_clear();
    check("rst lsb y_valid", y_valid_l, 1'b0);
    check("rst msb y_valid", y_valid_m, 1'b0);
    check("rst lsb y", y_l, 3'd0);
    check("rst lsb y_last", y_last_l, 1'b0);
    check("rst lsb d_ready", d_ready_l, 1'b1);
    check("rst msb d_ready", d_ready_m, 1'b1);
    check("rst lsb zero", zero_l, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       dv;
    logic       yr;
    logic       yv;
    logic [2:0] yl;
    logic [2:0] ym;
    logic       last;
    logic       drdy;
    logic       zero;
  } vec_t;

  vec_t tbl[13];
  int   log_l[$];
  int   log_m[$];

  initial begin
    logic [7:0] rw;
    d       = '0;
    d_valid = 1'b0;
    y_ready = 1'b0;
    rst     = 1'b0;
    model_clear();
    #1;
    do_reset();

    //             d      dv    yr    yv    yl    ym    last  drdy  zero
    tbl[0]  = '{8'hA4, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 3'd7, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 3'd5, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd7, 3'd2, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{8'h81, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{8'h10, 1'b1, 1'b1, 1'b1, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{8'h10, 1'b1, 1'b1, 1'b1, 3'd7, 3'd0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 3'd4, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0};

    foreach (tbl[i]) begin
      apply(tbl[i].d, tbl[i].dv, tbl[i].yr);
      check($sformatf("tbl%0d y_valid", i), y_valid_l, tbl[i].yv);
      check($sformatf("tbl%0d msb y_valid", i), y_valid_m, tbl[i].yv);
      check($sformatf("tbl%0d lsb y", i), y_l, tbl[i].yl);
      check($sformatf("tbl%0d msb y", i), y_m, tbl[i].ym);
      check($sformatf("tbl%0d lsb y_last", i), y_last_l, tbl[i].last);
      check($sformatf("tbl%0d msb y_last", i), y_last_m, tbl[i].last);
      check($sformatf("tbl%0d d_ready", i), d_ready_l, tbl[i].drdy);
      check($sformatf("tbl%0d zero", i), zero_l, tbl[i].zero);
      advance();
    end

    // All bits set with a stalling consumer: each index held while stalled,
    // eight handshakes, strictly ordered.
    cycle(8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      apply(8'h00, 1'b0, (i % 2) == 0);
      if (y_valid_l && y_ready) log_l.push_back(int'(y_l));
      if (y_valid_m && y_ready) log_m.push_back(int'(y_m));
      advance();
    end
    check("ff lsb handshakes", log_l.size(), 8);
    check("ff msb handshakes", log_m.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ff lsb order %0d", i), (i < log_l.size()) ? log_l[i] : -1, i);
      check($sformatf("ff msb order %0d", i), (i < log_m.size()) ? log_m[i] : -1, 7 - i);
    end

    // Reset in the middle of a word: indices 2 and 3 of 8'h0F must vanish.
    cycle(8'h0F, 1'b1, 1'b1);
    cycle(8'h00, 1'b0, 1'b1);
    cycle(8'h00, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(8'h00, 1'b0, 1'b1);
    // First edge after release accepts immediately.
    cycle(8'h02, 1'b1, 1'b1);
    apply(8'h00, 1'b0, 1'b1);
    check("post-rst first y", y_l, 3'd1);
    advance();

    // Randomized traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0:       rw = 8'h00;
        1:       rw = 8'h01 << $urandom_range(0, 7);
        default: rw = 8'($urandom());
      endcase
      if (n == 300) do_reset();
      cycle(rw, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 12; i++) cycle(8'h00, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_enc_8x3_seq
